dmem_responder: RTL and testbench

//  Multi-cycle data-memory responder: the memory-side end of the core's data-port interface.
//  The core is the initiator and provides address, write data, write enable and byte-store flag.

---
 rtl/dmem_responder.sv | 164 ++++++++++++++++
 tb/tb_dmem_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request, wait states, RMW byte stores and a
// one-cycle registered response. Define DMEM_BOUNDS_CHECK_EN to flag out-of-range addresses.
module dmem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic        req_byte_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = (WAIT_CYCLES == 0) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StBusy, StMerge, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              byte_q, byte_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merge_q, merge_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       mem_q [DEPTH];
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [AddrW-1:0]  idx;
  logic [31:0]       rd_word;
  logic              oob;
  logic [4:0]        sh;
  logic [31:0]       lane_mask;
  logic [31:0]       merged;

  assign idx     = addr_q[AddrW+1:2];
  assign rd_word = mem_q[idx];

`ifdef DMEM_BOUNDS_CHECK_EN
  assign oob = ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
`else
  // Upper address bits are dropped so the index wraps modulo DEPTH.
  logic unused_addr;
  assign unused_addr = ^addr_q[31:AddrW+2];
  assign oob         = 1'b0;
`endif

  // Big-endian byte lanes: addr[1:0]==0 selects bits 31:24.
  assign sh        = {addr_q[1:0], 3'b000};
  assign lane_mask = 32'hFF00_0000 >> sh;
  assign merged    = (merge_q & ~lane_mask) | ({wdata_q[7:0], 24'h00_0000} >> sh);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // A commit coinciding with reset is dropped along with the rest of the operation.
  always_ff @(posedge clk_i) begin
    if (mem_we && !reset_i) begin
      mem_q[idx] <= mem_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid_i) state_d = StBusy;
      StBusy: begin
        if (cnt_q == '0) state_d = (we_q && byte_q && !oob) ? StMerge : StResp;
      end
      StMerge: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    we_d      = we_q;
    byte_d    = byte_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    merge_d   = merge_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_wdata = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          byte_d  = req_byte_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          cnt_d   = CntInit;
        end
      end
      StBusy: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (oob) begin
          rdata_d = '0;
          err_d   = 1'b1;
        end else if (!we_q) begin
          rdata_d = rd_word;
          err_d   = 1'b0;
        end else if (!byte_q) begin
          mem_we    = 1'b1;
          mem_wdata = wdata_q;
          rdata_d   = wdata_q;
          err_d     = 1'b0;
        end else begin
          merge_d = rd_word;
        end
      end
      StMerge: begin
        mem_we    = 1'b1;
        mem_wdata = merged;
        rdata_d   = merged;
        err_d     = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == StIdle) && !reset_i;
    rsp_valid_o = (state_q == StResp) && !reset_i;
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: per-cycle reference model of handshake, latency and memory
// contents, plus directed transactions with hand-computed data and latency.
module tb_dmem_responder;

  localparam int unsigned DEPTH       = 64;
  localparam int unsigned WAIT_CYCLES = 1;
  localparam int          Lat         = WAIT_CYCLES + 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b1;
  logic        req_we = 1'b1;
  logic        req_byte = 1'b0;
  logic [31:0] req_addr = 32'h10;
  logic [31:0] req_wdata = 32'h0BAD_0BAD;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  dmem_responder #(
    .DEPTH      (DEPTH),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_we_i   (req_we),
    .req_byte_i (req_byte),
    .req_addr_i (req_addr),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o  (rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
  endtask

  function automatic bit out_of_range(input logic [31:0] a);
`ifdef DMEM_BOUNDS_CHECK_EN
    return a[31:2] >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: one outstanding request, result known at handshake, applied at response.
  logic [31:0] mmem [DEPTH];
  bit          pend = 1'b0;
  int          pend_cyc;
  int          pend_idx;
  bit          pend_wr;
  bit          pend_err;
  logic [31:0] pend_data;
  logic [31:0] last_rdata = '0;

  always @(negedge clk) begin
    bit          exp_ready;
    bit          exp_valid;
    logic [31:0] w;
    int          lane;
    if (cyc >= 1) begin
      exp_ready = !reset && !pend;
      exp_valid = pend && !reset && (cyc == pend_cyc);
      if (pend && cyc == pend_cyc) begin
        if (pend_wr) mmem[pend_idx] = pend_data;
        last_rdata = pend_data;
        pend = 1'b0;
      end
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      chk("rsp_rdata", rsp_rdata, last_rdata);
      if (exp_valid) chk("rsp_err", 32'(rsp_err), 32'(pend_err));
      if (reset) begin
        pend = 1'b0;
        last_rdata = '0;
      end else if (exp_ready && req_valid) begin
        pend     = 1'b1;
        pend_cyc = cyc + Lat;
        pend_idx = int'((req_addr >> 2) % DEPTH);
        pend_wr  = 1'b0;
        pend_err = 1'b0;
        if (out_of_range(req_addr)) begin
          pend_data = '0;
          pend_err  = 1'b1;
        end else if (!req_we) begin
          pend_data = mmem[pend_idx];
        end else if (!req_byte) begin
          pend_data = req_wdata;
          pend_wr   = 1'b1;
        end else begin
          w    = mmem[pend_idx];
          lane = int'(req_addr[1:0]);
          w[31-8*lane -: 8] = req_wdata[7:0];
          pend_data = w;
          pend_wr   = 1'b1;
          pend_cyc  = pend_cyc + 1;
        end
      end
    end
  end

  task automatic wait_hs(input string name, output int c0, output bit ok);
    ok = 1'b0;
    c0 = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        c0 = cyc;
      end
    end
    if (!ok) timeout({name, " handshake"});
  endtask

  task automatic do_req(input string name, input bit we, input bit byt, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_data,
                        input bit exp_err, input int exp_lat);
    int c0;
    bit ok;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_we    = we;
    req_byte  = byt;
    req_addr  = addr;
    req_wdata = wdata;
    wait_hs(name, c0, ok);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(negedge clk);
        if (rsp_valid) ok = 1'b1;
      end
      if (!ok) begin
        timeout({name, " response"});
      end else begin
        chk({name, " data"}, rsp_rdata, exp_data);
        chk({name, " err"}, 32'(rsp_err), 32'(exp_err));
        chk({name, " latency"}, 32'(cyc - c0), 32'(exp_lat));
      end
    end
  endtask

  initial begin
    int c0;
    bit ok;
    int n;
    int nrsp;
    int hs [3];

    // Reset held two cycles with a request pending: nothing may transfer.
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("ready after reset", 32'(req_ready), 32'd1);
    chk("rdata after reset", rsp_rdata, 32'h0);

    do_req("st_word", 1'b1, 1'b0, 32'h10, 32'h1234_5678, 32'h1234_5678, 1'b0, 3);
    do_req("ld_word", 1'b0, 1'b0, 32'h10, 32'h0, 32'h1234_5678, 1'b0, 3);

    do_req("st_20", 1'b1, 1'b0, 32'h20, 32'hAABB_CCDD, 32'hAABB_CCDD, 1'b0, 3);
    do_req("stb_21", 1'b1, 1'b1, 32'h21, 32'h0000_0011, 32'hAA11_CCDD, 1'b0, 4);
    do_req("stb_23", 1'b1, 1'b1, 32'h23, 32'hFFFF_FF22, 32'hAA11_CC22, 1'b0, 4);
    do_req("ld_20", 1'b0, 1'b0, 32'h20, 32'h0, 32'hAA11_CC22, 1'b0, 3);
    do_req("stb_20", 1'b1, 1'b1, 32'h20, 32'h0000_0099, 32'h9911_CC22, 1'b0, 4);
    do_req("ld_22", 1'b0, 1'b0, 32'h22, 32'h0, 32'h9911_CC22, 1'b0, 3);

    // Store aborted by reset while still counting wait states.
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_byte  = 1'b0;
    req_addr  = 32'h10;
    req_wdata = 32'hDEAD_BEEF;
    wait_hs("abort_st", c0, ok);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    nrsp  = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
    end
    chk("abort no rsp", 32'(nrsp), 32'd0);
    do_req("ld_after_abort", 1'b0, 1'b0, 32'h10, 32'h0, 32'h1234_5678, 1'b0, 3);

    // Back-to-back loads with req_valid held high.
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_byte  = 1'b0;
    req_addr  = 32'h20;
    n    = 0;
    nrsp = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
      if (req_ready) begin
        hs[n] = cyc;
        n++;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
    end
    chk("b2b handshakes", 32'(n), 32'd3);
    if (n == 3) begin
      chk("b2b spacing 0-1", 32'(hs[1] - hs[0]), 32'd4);
      chk("b2b spacing 1-2", 32'(hs[2] - hs[1]), 32'd4);
    end
    chk("b2b responses", 32'(nrsp), 32'd3);

    // Address beyond the array.
    do_req("st_0", 1'b1, 1'b0, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 3);
`ifdef DMEM_BOUNDS_CHECK_EN
    do_req("ld_100", 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 3);
    do_req("stb_101", 1'b1, 1'b1, 32'h101, 32'h77, 32'h0, 1'b1, 3);
    do_req("ld_0", 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b0, 3);
`else
    do_req("ld_100", 1'b0, 1'b0, 32'h100, 32'h0, 32'hCAFE_F00D, 1'b0, 3);
    do_req("stb_101", 1'b1, 1'b1, 32'h101, 32'h77, 32'hCA77_F00D, 1'b0, 4);
    do_req("ld_0", 1'b0, 1'b0, 32'h0, 32'h0, 32'hCA77_F00D, 1'b0, 3);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
